// File: rtl/opamp_duty_meter.sv
// -----------------------------------------------------------------------------
// opamp_duty_meter
//
// Measures the comparator output of the 3-stage opamp. The comparator pin is
// asynchronous, so it is synchronised (2 FFs) and then majority-filtered over
// the last three synced samples. After a settle period, a fixed window of
// 2**WIN_LOG2 cycles is observed. The meter counts the cycles in which the
// filtered level is high (duty) and the number of rising transitions
// (edge_cnt). The results are held until the next window completes.
//
// Handshake: res_valid is a single-cycle strobe with no back-pressure. It is
// high during the one DONE cycle. In that same cycle duty/edge_cnt already
// show the new result, and they keep that value until the next strobe.
// start is a single-cycle request. It is accepted only in IDLE or DONE and is
// dropped (not queued) while busy.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   comp_in    asynchronous comparator level from the analog macro
//   start      1-cycle pulse, begin a measurement
//   cont       1 = re-arm automatically after each DONE
//   busy       high in SETTLE and MEASURE
//   duty       high-time result (saturating), held between results
//   edge_cnt   rising edges in the window (saturating), held between results
//   res_valid  1-cycle pulse when duty/edge_cnt update
//   comp_filt  filtered comparator level (debug)
//   state_dbg  current FSM state encoding (debug)
// -----------------------------------------------------------------------------
module opamp_duty_meter #(
    parameter int WIN_LOG2   = 8,
    parameter int OUT_W      = 8,
    parameter int SETTLE_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             comp_in,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic [OUT_W-1:0] duty,
    output logic [OUT_W-1:0] edge_cnt,
    output logic             res_valid,
    output logic             comp_filt,
    output logic [1:0]       state_dbg
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int SHIFT = WIN_LOG2 - OUT_W;
    localparam logic [SET_W-1:0]    SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [OUT_W-1:0]    OUT_MAX     = '1;
    localparam logic [WIN_LOG2-1:0] WIN_LAST    = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [1:0]          hist_q, hist_d;
    logic                filt_q, filt_d;
    logic                filt_prev_q, filt_prev_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [WIN_LOG2-1:0] win_q, win_d;
    logic [WIN_LOG2:0]   ones_q, ones_d;
    logic [OUT_W-1:0]    edges_q, edges_d;
    logic [OUT_W-1:0]    duty_q, duty_d;
    logic [OUT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic                res_valid_q, res_valid_d;

    logic                rise;
    logic [WIN_LOG2:0]   ones_next;
    logic [OUT_W-1:0]    edges_next;
    logic [WIN_LOG2:0]   duty_shift;

    always_comb begin
        // Input path: synchroniser, then a 3-sample history for the majority vote.
        sync1_d     = comp_in;
        sync2_d     = sync1_q;
        hist_d      = {hist_q[0], sync2_q};
        // A single-cycle pulse can occupy only one of the three votes, so it
        // never reaches the filtered output.
        filt_d      = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
        filt_prev_d = filt_q;
        rise        = filt_q & ~filt_prev_q;

        ones_next  = ones_q + (WIN_LOG2 + 1)'(filt_q);
        edges_next = (rise && (edges_q != OUT_MAX)) ? edges_q + OUT_W'(1) : edges_q;
        duty_shift = ones_next >> SHIFT;

        state_d     = state_q;
        settle_d    = settle_q;
        win_d       = win_q;
        ones_d      = ones_q;
        edges_d     = edges_q;
        duty_d      = duty_q;
        edge_cnt_d  = edge_cnt_q;
        res_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                end
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_MEASURE;
                    win_d   = '0;
                    ones_d  = '0;
                    edges_d = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            S_MEASURE: begin
                ones_d  = ones_next;
                edges_d = edges_next;
                win_d   = win_q + WIN_LOG2'(1);
                // The result is loaded on the way into DONE, so it is already
                // visible while res_valid is high in DONE. It includes the
                // sample taken in this last window cycle.
                if (win_q == WIN_LAST) begin
                    state_d     = S_DONE;
                    res_valid_d = 1'b1;
                    edge_cnt_d  = edges_next;
                    // An all-high window gives 2**WIN_LOG2 ones, which is one
                    // more than the result can hold.
                    if (duty_shift > (WIN_LOG2 + 1)'(OUT_MAX)) begin
                        duty_d = OUT_MAX;
                    end else begin
                        duty_d = duty_shift[OUT_W-1:0];
                    end
                end
            end
            S_DONE: begin
                if (cont || start) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            hist_q      <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            settle_q    <= '0;
            win_q       <= '0;
            ones_q      <= '0;
            edges_q     <= '0;
            duty_q      <= '0;
            edge_cnt_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            hist_q      <= hist_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            settle_q    <= settle_d;
            win_q       <= win_d;
            ones_q      <= ones_d;
            edges_q     <= edges_d;
            duty_q      <= duty_d;
            edge_cnt_q  <= edge_cnt_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign busy      = (state_q == S_SETTLE) || (state_q == S_MEASURE);
    assign duty      = duty_q;
    assign edge_cnt  = edge_cnt_q;
    assign res_valid = res_valid_q;
    assign comp_filt = filt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_opamp_duty_meter.sv
// -----------------------------------------------------------------------------
// Directed bench for opamp_duty_meter. A default instance (window 256, settle
// 16) and a WIN_LOG2=10 instance share clk, rst and comp_in. comp_in is driven
// on the falling edge from a pattern selector. All DUT outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_opamp_duty_meter;

    logic       clk;
    logic       rst;
    logic       comp_in;
    logic       start;
    logic       cont;
    logic       start10;
    logic       cont10;

    logic       busy;
    logic [7:0] duty;
    logic [7:0] edge_cnt;
    logic       res_valid;
    logic       comp_filt;
    logic [1:0] state_dbg;

    logic       busy_10;
    logic [7:0] duty_10;
    logic [7:0] edge_cnt_10;
    logic       res_valid_10;
    logic       comp_filt_10;
    logic [1:0] state_dbg_10;

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;   // 0 low, 1 high, 2 square 32/32, 3 glitches, 4 toggle 2/2
    int ph      = 0;

    opamp_duty_meter dut (
        .clk       (clk),
        .rst       (rst),
        .comp_in   (comp_in),
        .start     (start),
        .cont      (cont),
        .busy      (busy),
        .duty      (duty),
        .edge_cnt  (edge_cnt),
        .res_valid (res_valid),
        .comp_filt (comp_filt),
        .state_dbg (state_dbg)
    );

    opamp_duty_meter #(.WIN_LOG2(10), .OUT_W(8), .SETTLE_CYC(16)) dut10 (
        .clk       (clk),
        .rst       (rst),
        .comp_in   (comp_in),
        .start     (start10),
        .cont      (cont10),
        .busy      (busy_10),
        .duty      (duty_10),
        .edge_cnt  (edge_cnt_10),
        .res_valid (res_valid_10),
        .comp_filt (comp_filt_10),
        .state_dbg (state_dbg_10)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: observed no end, required finish before 3ms");
        $fatal(1, "watchdog");
    end

    // Comparator pattern driver
    initial begin
        comp_in = 1'b0;
        forever begin
            @(negedge clk);
            ph++;
            case (mode)
                1:       comp_in = 1'b1;
                2:       comp_in = ((ph % 64) < 32);
                3:       comp_in = ((ph % 10) == 0);
                4:       comp_in = ((ph % 4) < 2);
                default: comp_in = 1'b0;
            endcase
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp, input int tol);
        n_tests++;
        assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d+-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Advance falling edges until res_valid is seen (bounded). Returns the
    // number of edges advanced, the busy cycles and the comp_filt-high cycles
    // seen along the way.
    task automatic wait_result(input bit use10, input int limit, input string tag,
                               output int cycles, output int busy_cyc, output int filt_hi);
        bit got;
        got      = 1'b0;
        cycles   = 0;
        busy_cyc = 0;
        filt_hi  = 0;
        while (!got && cycles < limit) begin
            if (use10 ? res_valid_10 : res_valid) begin
                got = 1'b1;
            end else begin
                if (use10 ? busy_10 : busy) busy_cyc++;
                if (comp_filt) filt_hi++;
                @(negedge clk);
                cycles++;
            end
        end
        check({tag, "_seen"}, int'(got), 1);
    endtask

    task automatic count_rv(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (res_valid) cnt++;
        end
    endtask

    initial begin
        int cyc;
        int bc;
        int fh;
        int rv;
        int elapsed;

        rst     = 1'b1;
        start   = 1'b0;
        cont    = 1'b0;
        start10 = 1'b0;
        cont10  = 1'b0;
        mode    = 1;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_busy",      int'(busy), 0);
        check("rst_duty",      int'(duty), 0);
        check("rst_edge",      int'(edge_cnt), 0);
        check("rst_rv",        int'(res_valid), 0);
        check("rst_filt",      int'(comp_filt), 0);
        check("rst_state",     int'(state_dbg), 0);
        rst = 1'b0;

        // 1: constant high input, single measurement
        repeat (10) @(negedge clk);
        check("t1_filt_high", int'(comp_filt), 1);
        pulse_start();
        wait_result(1'b0, 2000, "t1", cyc, bc, fh);
        check("t1_latency", cyc, 272);
        check("t1_busy_cyc", bc, 272);
        check("t1_busy_done", int'(busy), 0);
        check("t1_duty", int'(duty), 255);
        check("t1_edge", int'(edge_cnt), 0);
        count_rv(300, rv);
        check("t1_no_rearm", rv, 0);
        check("t1_idle", int'(state_dbg), 0);
        check("t1_duty_held", int'(duty), 255);

        // 2: square 32/32 with cont=1, then cont cleared mid-window
        mode = 2;
        cont = 1'b1;
        repeat (80) @(negedge clk);
        pulse_start();
        wait_result(1'b0, 2000, "t2_w0", cyc, bc, fh);
        check("t2_w0_latency", cyc, 272);
        check_near("t2_w0_duty", int'(duty), 128, 1);
        check("t2_w0_edge", int'(edge_cnt), 4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wait_result(1'b0, 2000, "t2_wn", cyc, bc, fh);
            check("t2_period", cyc + 1, 273);
            check_near("t2_duty", int'(duty), 128, 1);
            check("t2_edge", int'(edge_cnt), 4);
        end
        @(negedge clk);
        repeat (100) @(negedge clk);
        cont = 1'b0;
        wait_result(1'b0, 2000, "t2_last", cyc, bc, fh);
        check("t2_last_remaining", cyc, 172);
        count_rv(400, rv);
        check("t2_stop_after_cont_clear", rv, 0);
        check("t2_idle", int'(state_dbg), 0);

        // 3: low input with single-cycle glitches
        mode = 3;
        repeat (20) @(negedge clk);
        pulse_start();
        wait_result(1'b0, 2000, "t3", cyc, bc, fh);
        check("t3_latency", cyc, 272);
        check("t3_filt_hi_cycles", fh, 0);
        check("t3_duty", int'(duty), 0);
        check("t3_edge", int'(edge_cnt), 0);

        // 4: toggle every 2 cycles, both window sizes
        mode = 4;
        repeat (20) @(negedge clk);
        @(negedge clk);
        start   = 1'b1;
        start10 = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        start10 = 1'b0;
        wait_result(1'b0, 2000, "t4", cyc, bc, fh);
        check("t4_latency", cyc, 272);
        check_near("t4_duty", int'(duty), 128, 1);
        check("t4_edge", int'(edge_cnt), 64);
        wait_result(1'b1, 2000, "t4_w10", cyc, bc, fh);
        check("t4_w10_latency", cyc, 768);
        check_near("t4_w10_duty", int'(duty_10), 128, 1);
        check("t4_w10_edge_sat", int'(edge_cnt_10), 255);

        // 5: reset 100 cycles into MEASURE
        mode = 1;
        repeat (10) @(negedge clk);
        pulse_start();
        repeat (116) @(negedge clk);
        check("t5_busy_before_rst", int'(busy), 1);
        check("t5_state_measure", int'(state_dbg), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", int'(busy), 0);
        check("t5_duty", int'(duty), 0);
        check("t5_edge", int'(edge_cnt), 0);
        check("t5_rv", int'(res_valid), 0);
        check("t5_filt", int'(comp_filt), 0);
        check("t5_state", int'(state_dbg), 0);
        count_rv(400, rv);
        check("t5_no_rv_after_abort", rv, 0);
        repeat (10) @(negedge clk);
        pulse_start();
        wait_result(1'b0, 2000, "t5_redo", cyc, bc, fh);
        check("t5_redo_latency", cyc, 272);
        check("t5_redo_duty", int'(duty), 255);
        check("t5_redo_edge", int'(edge_cnt), 0);

        // 6: start while busy is dropped; start in DONE re-arms
        repeat (10) @(negedge clk);
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        repeat (140) @(negedge clk);
        pulse_start();
        wait_result(1'b0, 2000, "t6", cyc, bc, fh);
        elapsed = 5 + 2 + 140 + 2 + cyc;
        check("t6_window_len", elapsed, 272);
        check("t6_duty", int'(duty), 255);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t6_rearm_busy", int'(busy), 1);
        wait_result(1'b0, 2000, "t6_rearm", cyc, bc, fh);
        check("t6_rearm_period", cyc + 1, 273);
        count_rv(300, rv);
        check("t6_no_extra_rv", rv, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
